// File: rtl/video_pkg.sv
// video_pkg: shared video pipeline types, default timing and RGB565 colour-bar constants
package video_pkg;
  typedef enum logic [1:0] {WAIT_VSYNC, SKIP, CAPTURE} cap_state_t;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;
  // Index 0 is the leftmost bar (white).
  localparam logic [7:0][15:0] COLOR_BARS = {RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
                                             RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE};
endpackage

// File: rtl/dvp_byte_pair.sv
// dvp_byte_pair: registers the DVP bus, detects vsync/href edges and pairs bytes into RGB565 words
// Ports: clock/reset (async, active-high); cam_vsync, cam_href, cam_data from the sensor;
// vs_fall/vs_rise frame start/end, href_fall line end, word_valid/word completed pixel.
module dvp_byte_pair #(
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        vs_fall,
  output logic        vs_rise,
  output logic        href_fall,
  output logic        word_valid,
  output logic [15:0] word
);
  logic vs_q, vs_d, href_q, href_d, phase;
  logic [7:0] data_q, byte0;
  // vs reset to blanking so a sensor already in blanking produces no spurious frame end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vs_q   <= 1'b1;
      vs_d   <= 1'b1;
      href_q <= 1'b0;
      href_d <= 1'b0;
      phase  <= 1'b0;
      data_q <= '0;
      byte0  <= '0;
    end else begin
      vs_q   <= cam_vsync ~^ VSYNC_ACTIVE_HIGH;
      vs_d   <= vs_q;
      href_q <= cam_href;
      href_d <= href_q;
      data_q <= cam_data;
      phase  <= href_q & ~phase;
      if (href_q & ~phase) byte0 <= data_q;
    end
  end
  assign vs_fall    = vs_d & ~vs_q;
  assign vs_rise    = ~vs_d & vs_q;
  assign href_fall  = href_d & ~href_q;
  assign word_valid = href_q & phase;
  assign word       = {byte0, data_q};
endmodule

// File: rtl/ov5640_dvp_capture.sv
// ov5640_dvp_capture: OV5640 DVP capture writing RGB565 pixels into the async pixel FIFO
// Ports: clock (PCLK), reset (async, active-high); cam_vsync/cam_href/cam_data sensor bus;
// full_fifo write-side full flag; clear_status clears sticky flags; fifo_write_en/fifo_data_out
// FIFO write port; frame_start, capturing, overflow, frame_error, frame_count status.
// Define CAPTURE_TEST_PATTERN_EN to replace captured pixels with 8 vertical colour bars.
module ov5640_dvp_capture
  import video_pkg::*;
#(
  parameter int H_ACTIVE          = H_ACTIVE_DEF,
  parameter int V_ACTIVE          = V_ACTIVE_DEF,
  parameter int SKIP_FRAMES       = 2,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        full_fifo,
  input  logic        clear_status,
  output logic        fifo_write_en,
  output logic [15:0] fifo_data_out,
  output logic        frame_start,
  output logic        capturing,
  output logic        overflow,
  output logic        frame_error,
  output logic [15:0] frame_count
);
  cap_state_t state;
  logic [15:0] skip_cnt, word, pix_word;
  logic [10:0] pix;
  logic [9:0] lines;
  logic vs_fall, vs_rise, href_fall, word_valid;
  logic skip_done, start_ev, in_cap, wr, drop, line_err, frame_err_ev;
  dvp_byte_pair #(.VSYNC_ACTIVE_HIGH(VSYNC_ACTIVE_HIGH)) u_pair (
    .clock(clock), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .vs_fall(vs_fall), .vs_rise(vs_rise), .href_fall(href_fall), .word_valid(word_valid), .word(word)
  );
`ifdef CAPTURE_TEST_PATTERN_EN
  assign pix_word = COLOR_BARS[pix[9:7]];
`else
  assign pix_word = word;
`endif
  assign in_cap       = state == CAPTURE;
  assign skip_done    = state == SKIP && skip_cnt >= 16'(SKIP_FRAMES);
  // The frame start that leaves SKIP is already the first captured frame.
  assign start_ev     = vs_fall && (in_cap || skip_done);
  assign wr           = in_cap && word_valid && !full_fifo;
  assign drop         = in_cap && word_valid && full_fifo;
  assign line_err     = in_cap && href_fall && pix != 11'(H_ACTIVE);
  assign frame_err_ev = in_cap && vs_rise && lines != 10'(V_ACTIVE);
  assign frame_start  = start_ev;
  assign capturing    = in_cap;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= WAIT_VSYNC;
      skip_cnt      <= '0;
      pix           <= '0;
      lines         <= '0;
      fifo_write_en <= 1'b0;
      fifo_data_out <= '0;
      overflow      <= 1'b0;
      frame_error   <= 1'b0;
      frame_count   <= '0;
    end else begin
      state         <= start_ev ? CAPTURE : (state == WAIT_VSYNC && vs_rise) ? SKIP : state;
      skip_cnt      <= state == WAIT_VSYNC ? '0 : (state == SKIP && vs_rise && !skip_done) ? skip_cnt + 16'd1 : skip_cnt;
      fifo_write_en <= wr;
      if (wr) fifo_data_out <= pix_word;
      overflow      <= drop | (overflow & ~clear_status);
      frame_error   <= line_err | frame_err_ev | (frame_error & ~clear_status);
      if (start_ev) begin
        pix         <= '0;
        lines       <= '0;
        frame_count <= frame_count + 16'd1;
      end else if (in_cap && href_fall) begin
        pix   <= '0;
        lines <= lines + 10'(lines != '1);
      end else if (in_cap && word_valid) begin
        pix <= pix + 11'(pix != '1);
      end
    end
  end
endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// tb_ov5640_dvp_capture: randomized DVP stimulus checked every cycle against a behavioural model
module tb_ov5640_dvp_capture;
  localparam int H = 200, V = 3, SKIP = 2;
  logic clock = 1'b0, reset = 1'b1, cam_vsync = 1'b1, cam_href = 1'b0, full_fifo = 1'b0, clear_status = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic fifo_write_en, frame_start, capturing, overflow, frame_error;
  logic [15:0] fifo_data_out, frame_count;
  int checks = 0, errors = 0, wr_cnt = 0;
`ifdef CAPTURE_TEST_PATTERN_EN
  int ffff_cnt = 0, ffe0_cnt = 0;
`else
  int f81f_cnt = 0;
`endif
  always #5 clock = ~clock;

  ov5640_dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SKIP), .VSYNC_ACTIVE_HIGH(1'b1)) dut (
    .clock(clock), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .full_fifo(full_fifo), .clear_status(clear_status), .fifo_write_en(fifo_write_en),
    .fifo_data_out(fifo_data_out), .frame_start(frame_start), .capturing(capturing),
    .overflow(overflow), .frame_error(frame_error), .frame_count(frame_count)
  );

  // model: mode 0 = waiting for sync, 1 = skipping, 2 = capturing
  int mode, skips, pix, lines, fcount, run1;
  bit ovf, ferr, exp_we, exp_fs, pv1, pv2, ph1, ph2;
  logic [15:0] exp_data;
  logic [7:0] pd1, pd2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef CAPTURE_TEST_PATTERN_EN
  function automatic logic [15:0] bar(input int p);
    logic [15:0] b [8];
    b = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    return b[(p >> 7) & 7];
  endfunction
`endif

  task automatic model_reset();
    mode = 0; skips = 0; pix = 0; lines = 0; fcount = 0; run1 = 0;
    ovf = 0; ferr = 0; exp_we = 0; exp_fs = 0; exp_data = 16'h0;
    pv1 = 1; pv2 = 1; ph1 = 0; ph2 = 0; pd1 = 8'h0; pd2 = 8'h0;
  endtask

  // Events seen by the design at an edge come from the two previous input samples;
  // a pixel completes when the current href run has delivered an even number of bytes.
  task automatic model_step(input bit v, input bit h, input logic [7:0] d, input bit f, input bit clr);
    bit fall, rise, hfall, pair, so, se;
    fall = pv2 && !pv1; rise = !pv2 && pv1; hfall = ph2 && !ph1; pair = ph1 && (run1 % 2 == 0);
    so = 0; se = 0; exp_we = 0;
    if (mode == 2) begin
      if (hfall && pix != H) se = 1;
      if (rise && lines != V) se = 1;
      if (fall) begin
        pix = 0; lines = 0; fcount = (fcount + 1) & 16'hFFFF;
      end else if (hfall) begin
        lines = lines < 1023 ? lines + 1 : 1023; pix = 0;
      end else if (pair) begin
        if (f) so = 1;
        else begin
          exp_we = 1;
`ifdef CAPTURE_TEST_PATTERN_EN
          exp_data = bar(pix);
`else
          exp_data = {pd2, pd1};
`endif
        end
        pix = pix < 2047 ? pix + 1 : 2047;
      end
    end else if (mode == 1) begin
      if (fall && skips >= SKIP) begin
        mode = 2; pix = 0; lines = 0; fcount = (fcount + 1) & 16'hFFFF;
      end else if (rise && skips < SKIP) skips++;
    end else if (rise) begin
      mode = 1; skips = 0;
    end
    ovf = so || (ovf && !clr);
    ferr = se || (ferr && !clr);
    pv2 = pv1; pv1 = v; ph2 = ph1; ph1 = h; pd2 = pd1; pd1 = d;
    run1 = h ? run1 + 1 : 0;
    exp_fs = pv2 && !pv1 && (mode == 2 || (mode == 1 && skips >= SKIP));
  endtask

  always @(posedge clock) begin
    if (reset) model_reset();
    else model_step(cam_vsync, cam_href, cam_data, full_fifo, clear_status);
    #2;
    if (reset) model_reset();
    chk("write_en", fifo_write_en, exp_we);
    chk("data_out", fifo_data_out, exp_data);
    chk("frame_start", frame_start, exp_fs);
    chk("capturing", capturing, mode == 2);
    chk("overflow", overflow, ovf);
    chk("frame_error", frame_error, ferr);
    chk("frame_count", frame_count, fcount);
    if (fifo_write_en) begin
      wr_cnt++;
`ifdef CAPTURE_TEST_PATTERN_EN
      if (fifo_data_out == 16'hFFFF) ffff_cnt++;
      if (fifo_data_out == 16'hFFE0) ffe0_cnt++;
`else
      if (fifo_data_out == 16'hF81F) f81f_cnt++;
`endif
    end
  end

  task automatic cyc(input bit vb, input bit h, input logic [7:0] d, input bit f);
    cam_vsync = vb; cam_href = h; cam_data = d; full_fifo = f;
    @(posedge clock); #1;
    clear_status = 1'b0;
  endtask

  task automatic idle(input int n, input bit vb);
    repeat (n) cyc(vb, 1'b0, 8'($urandom), 1'b0);
  endtask

  // m: 0 = 0xF8,0x1F pattern, 1 = random, 2 = random with full over words w0..w0+9, 3 = random full
  task automatic line(input int nb, input int m, input int w0 = 0);
    for (int j = 0; j < nb; j++)
      cyc(1'b0, 1'b1, m == 0 ? (j % 2 ? 8'h1F : 8'hF8) : 8'($urandom),
          m == 2 ? (j >= 2 * w0 + 2 && j < 2 * w0 + 22) : m == 3 ? ($urandom % 4 == 0) : 1'b0);
    idle(6, 1'b0);
  endtask

  task automatic fbegin(); idle(3, 1'b0); endtask
  task automatic fend(); idle(6, 1'b1); endtask
  task automatic frame(input int m);
    fbegin();
    repeat (V) line(2 * H, m);
    fend();
  endtask

  initial begin
    int w, n, nb;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_flags", {fifo_write_en, frame_start, capturing, overflow, frame_error}, 0);
    chk("reset_data", fifo_data_out, 0);
    chk("reset_count", frame_count, 0);
    reset = 1'b0;
    idle(4, 1'b1); idle(5, 1'b0); idle(5, 1'b1);
    w = wr_cnt; frame(0); frame(0);
    chk("skip_writes", wr_cnt - w, 0);
    w = wr_cnt; fbegin();
    chk("first_fcount", frame_count, 1);
    repeat (V) line(2 * H, 0);
    fend();
    chk("frameA_writes", wr_cnt - w, H * V);
`ifdef CAPTURE_TEST_PATTERN_EN
    chk("bar_white", ffff_cnt, 128 * V);
    chk("bar_yellow", ffe0_cnt, (H - 128) * V);
`else
    chk("f81f_writes", f81f_cnt, H * V);
`endif
    chk("frameA_error", frame_error, 0);
    fbegin(); w = wr_cnt;
    line(2 * H, 2, 50);
    chk("full_writes", wr_cnt - w, H - 10);
    chk("overflow_set", overflow, 1);
    clear_status = 1'b1; idle(2, 1'b0);
    chk("overflow_clr", overflow, 0);
    repeat (V - 1) line(2 * H, 1);
    fend();
    chk("frameB_error", frame_error, 0);
    chk("frameB_fcount", frame_count, 2);
    fbegin();
    line(2 * H - 2, 1);
    chk("short_line_err", frame_error, 1);
    w = wr_cnt;
    repeat (V - 1) line(2 * H, 1);
    chk("after_short_writes", wr_cnt - w, H * (V - 1));
    fend();
    clear_status = 1'b1; idle(2, 1'b1);
    chk("error_clr", frame_error, 0);
    fbegin(); w = wr_cnt;
    line(2 * H + 1, 1);
    chk("odd_line_writes", wr_cnt - w, H);
    w = wr_cnt;
    line(2 * H, 1);
    chk("after_odd_writes", wr_cnt - w, H);
    line(2 * H, 1);
    fend();
    chk("odd_frame_error", frame_error, 0);
    repeat (3) begin
      fbegin();
      n = 2 + $urandom % 3;
      repeat (n) begin
        case ($urandom % 4)
          0: nb = 2 * H - 2;
          1: nb = 2 * H + 1;
          default: nb = 2 * H;
        endcase
        line(nb, 3);
        if ($urandom % 3 == 0) begin clear_status = 1'b1; idle(1, 1'b0); end
      end
      fend();
    end
    fbegin();
    for (int j = 0; j < 51; j++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
    reset = 1'b1;
    #1;
    chk("midreset_flags", {fifo_write_en, frame_start, capturing, overflow, frame_error}, 0);
    chk("midreset_data", fifo_data_out, 0);
    chk("midreset_count", frame_count, 0);
    idle(2, 1'b0);
    reset = 1'b0;
    w = wr_cnt;
    repeat (V - 1) line(2 * H, 1);
    fend();
    frame(1); frame(1);
    chk("reskip_writes", wr_cnt - w, 0);
    w = wr_cnt; fbegin();
    chk("recapture_fcount", frame_count, 1);
    repeat (V) line(2 * H, 1);
    fend();
    chk("recapture_writes", wr_cnt - w, H * V);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ov5640_dvp_capture.md
# ov5640_dvp_capture

Camera-side writer for the video pipeline: samples the OV5640 8-bit DVP bus (`cam_vsync`, `cam_href`, `cam_data`) in the camera pixel-clock domain, pairs bytes into RGB565 words and pushes them into the asynchronous pixel FIFO that the HDMI output stage drains. It discards the first frames after start-up so the sensor can settle, gates writes on FIFO full, and reports frame, line and overflow status for debug.

## Interface
- `H_ACTIVE`, 640: RGB565 pixels expected per line.
- `V_ACTIVE`, 480: lines expected per frame.
- `SKIP_FRAMES`, 2: complete frames discarded after reset before capture starts (0 = capture the first complete frame).
- `VSYNC_ACTIVE_HIGH`, 1: 1 = `cam_vsync` high marks vertical blanking; 0 = inverted.
- `clock  in  1`: camera PCLK. All logic runs on its rising edge.
- `reset  in  1`: asynchronous, active-high.
- `cam_vsync  in  1`: frame sync from sensor.
- `cam_href  in  1`: line-valid from sensor.
- `cam_data  in  8`: DVP data byte.
- `full_fifo  in  1`: FIFO full flag, write-domain.
- `clear_status  in  1`: one-cycle pulse; clears the sticky flags.
- `fifo_write_en  out  1`: one-cycle write strobe.
- `fifo_data_out  out  16`: RGB565 word, valid when `fifo_write_en` is high.
- `frame_start  out  1`: one-cycle pulse at each captured frame start.
- `capturing  out  1`: high while in CAPTURE.
- `overflow  out  1`: sticky; set when a pixel is dropped because the FIFO was full.
- `frame_error  out  1`: sticky; set on a line-length or line-count mismatch.
- `frame_count  out  16`: captured frames, wraps at 0xFFFF→0.

## Operation
- Input stage: `cam_vsync`, `cam_href` and `cam_data` are registered once. All logic uses the registered copies. `vs` is the polarity-normalised vsync, 1 = blanking.
- Frame-start event: falling edge of `vs`. Frame-end event: rising edge of `vs`.
- Byte pairing, while registered href is high:
  - The byte phase toggles every cycle.
  - Byte 0 = {R[4:0],G[5:3]}; byte 1 = {G[2:0],B[4:0]}; word = {byte0, byte1}.
  - The phase is forced to 0 whenever href is low, so a line with an odd byte count drops the trailing byte.
- FSM:
  - WAIT_VSYNC (reset state): wait for the first frame-end event, which syncs to a frame boundary. Then go to SKIP, with skip count = 0.
  - SKIP: count frame-end events. When the count reaches `SKIP_FRAMES`, go to CAPTURE on the next frame-start event. If `SKIP_FRAMES` = 0, go straight to CAPTURE on the next frame-start event.
  - CAPTURE: on each frame-start event:
    - pulse `frame_start`;
    - zero the pixel and line counters;
    - increment `frame_count`.
- Pixel handling in CAPTURE: each completed word is written if `full_fifo` is low. Otherwise it is dropped and `overflow` is set. A dropped pixel still advances the pixel counter.
- Line check: on the falling edge of href, `frame_error` is set if the pixel counter ≠ `H_ACTIVE`. The line counter then increments and the pixel counter clears.
- Frame check: on a frame-end event, `frame_error` is set if the line counter ≠ `V_ACTIVE`.
- Counter widths: pixel counter is 11 bits and saturates at 2047; line counter is 10 bits and saturates at 1023.
- `clear_status` clears `overflow` and `frame_error`. A set condition in the same cycle wins.
- A `reset` assertion mid-frame returns the block to WAIT_VSYNC. The partial frame already in the FIFO is the consumer's concern.

## Timing
- Reset values:
  - `fifo_write_en`, `frame_start`, `capturing`, `overflow`, `frame_error` = 0;
  - `fifo_data_out` = 0x0000;
  - `frame_count` = 0;
  - FSM state = WAIT_VSYNC.
- Latency: if byte 1 is on `cam_data` at edge N, `fifo_write_en` and `fifo_data_out` are valid for exactly the cycle N+1→N+2.
- Full-flag timing: `full_fifo` is sampled unregistered at edge N+1, the same edge that would assert the write. No write is ever issued while `full_fifo` is high.
- `frame_start` is high for the one cycle after the edge at which the registered `vs` falls.
- Maximum write rate is one word every 2 clocks, so no back-to-back strobes.

## Configuration
- `CAPTURE_TEST_PATTERN_EN`: when defined, words written in CAPTURE are replaced by 8 vertical colour bars. The bar index is pixel counter[9:7], mapped to white, yellow, cyan, green, magenta, red, blue, black (0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000).
- With the macro defined, timing, strobes, full gating and status are unchanged.
- When the macro is undefined, camera data passes through unchanged.

## Structure
- Shared package `video_pkg`: FSM state encoding (WAIT_VSYNC, SKIP, CAPTURE), the default `H_ACTIVE`/`V_ACTIVE`, and the RGB565 colour-bar constants. The package is shared with the HDMI output stage.
- One natural sub-module, `dvp_byte_pair`: input registers, edge detect and byte-to-RGB565 assembly.

## Test plan
- SKIP_FRAMES=2, three 640×480 frames with byte pattern 0xF8,0x1F per pixel → zero writes during the first two frames; frame 3 gives 307200 writes of 0xF81F, `frame_count`=1, `frame_error`=0.
- `full_fifo` held high for 10 word slots mid-line → exactly 10 fewer writes, `overflow`=1; a `clear_status` pulse then returns `overflow` to 0.
- One line of 639 pixels in a captured frame → `frame_error`=1 at that line's href fall; the following 640-pixel lines still write normally.
- Line with 1281 bytes → 640 writes; the odd byte is dropped with no misalignment on the next line.
- `reset` pulsed mid-line in CAPTURE → all outputs read 0 on the next edge; no writes until SKIP completes again.
- `CAPTURE_TEST_PATTERN_EN` defined, one frame → pixels 0–127 write 0xFFFF, pixels 128–255 write 0xFFE0, pixels 896+ do not occur (the H_ACTIVE=640 line ends at bar 4, 0xF81F).
